// File: rtl/multicycle_control_if.sv
// Control/handshake bundle between the multicycle sequencer and the DPTR datapath.
// Optional MC_RETIRE_COUNT_EN adds the retired-instruction count.
interface multicycle_control_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 4
);
    logic [OPCODE_W-1:0] ctrl_i;
    logic [OPCODE_W-1:0] funct_i;
    logic                rotation_i;
    logic                memReady_i;
    logic                pcWrite_o;
    logic                irWrite_o;
    logic                iOrD_o;
    logic                memToRead_o;
    logic                memToWrite_o;
    logic                regDst_o;
    logic                memToReg_o;
    logic                regWrite_o;
    logic                aluSrcA_o;
    logic                aluSrcB_o;
    logic [ALUOP_W-1:0]  aluOp_o;
    logic [1:0]          branchType_o;
    logic                jump_o;
    logic [2:0]          state_o;
    logic                illegal_o;
`ifdef MC_RETIRE_COUNT_EN
    logic [31:0]         retired_o;
`endif

    modport master (
        input  ctrl_i, funct_i, rotation_i, memReady_i,
        output pcWrite_o, irWrite_o, iOrD_o, memToRead_o, memToWrite_o, regDst_o,
        output memToReg_o, regWrite_o, aluSrcA_o, aluSrcB_o, aluOp_o, branchType_o,
        output jump_o, state_o, illegal_o
`ifdef MC_RETIRE_COUNT_EN
        , output retired_o
`endif
    );

    modport slave (
        output ctrl_i, funct_i, rotation_i, memReady_i,
        input  pcWrite_o, irWrite_o, iOrD_o, memToRead_o, memToWrite_o, regDst_o,
        input  memToReg_o, regWrite_o, aluSrcA_o, aluSrcB_o, aluOp_o, branchType_o,
        input  jump_o, state_o, illegal_o
`ifdef MC_RETIRE_COUNT_EN
        , input retired_o
`endif
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the DPTR MIPS-subset datapath.
// Define MC_RETIRE_COUNT_EN to add the 32-bit retired-instruction counter.
module multicycle_control #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    multicycle_control_if.master bus
);
    localparam logic [OPCODE_W-1:0] OpRType = 6'b000000;
    localparam logic [OPCODE_W-1:0] OpAddi  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OpAndi  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OpOri   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OpSlti  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OpXori  = 6'b001110;
    localparam logic [OPCODE_W-1:0] OpLw    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OpSw    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OpBeq   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OpBne   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OpBgtz  = 6'b000111;
    localparam logic [OPCODE_W-1:0] OpJ     = 6'b000010;
    localparam logic [OPCODE_W-1:0] FnSll   = 6'b000000;
    localparam logic [OPCODE_W-1:0] FnSrl   = 6'b000010;

    localparam logic [ALUOP_W-1:0] AluAddr   = 4'b0000;
    localparam logic [ALUOP_W-1:0] AluBranch = 4'b0001;
    localparam logic [ALUOP_W-1:0] AluRType  = 4'b0010;
    localparam logic [ALUOP_W-1:0] AluAddi   = 4'b0011;
    localparam logic [ALUOP_W-1:0] AluAndi   = 4'b0100;
    localparam logic [ALUOP_W-1:0] AluOri    = 4'b0101;
    localparam logic [ALUOP_W-1:0] AluSlti   = 4'b0110;
    localparam logic [ALUOP_W-1:0] AluXori   = 4'b0111;
    localparam logic [ALUOP_W-1:0] AluSll    = 4'b1000;
    localparam logic [ALUOP_W-1:0] AluSrl    = 4'b1001;
    localparam logic [ALUOP_W-1:0] AluRotr   = 4'b1011;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } stateT;

    stateT               stateQ, stateD;
    logic [OPCODE_W-1:0] opQ, functQ;
    logic                rotQ;
    logic                illegalQ;

    function automatic logic isSupported(input logic [OPCODE_W-1:0] op);
        case (op)
            OpRType, OpAddi, OpAndi, OpOri, OpSlti, OpXori,
            OpLw, OpSw, OpBeq, OpBne, OpBgtz, OpJ: isSupported = 1'b1;
            default:                               isSupported = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stateQ   <= StFetch;
            opQ      <= '0;
            functQ   <= '0;
            rotQ     <= 1'b0;
            illegalQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            if (stateQ == StDecode) begin
                opQ    <= bus.ctrl_i;
                functQ <= bus.funct_i;
                rotQ   <= bus.rotation_i;
                if (!isSupported(bus.ctrl_i)) begin
                    illegalQ <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        stateD           = stateQ;
        bus.pcWrite_o    = 1'b0;
        bus.irWrite_o    = 1'b0;
        bus.iOrD_o       = 1'b0;
        bus.memToRead_o  = 1'b0;
        bus.memToWrite_o = 1'b0;
        bus.regDst_o     = 1'b0;
        bus.memToReg_o   = 1'b0;
        bus.regWrite_o   = 1'b0;
        bus.aluSrcA_o    = 1'b0;
        bus.aluSrcB_o    = 1'b0;
        bus.aluOp_o      = '0;
        bus.branchType_o = 2'b00;
        bus.jump_o       = 1'b0;

        case (stateQ)
            StFetch: begin
                bus.memToRead_o = 1'b1;
                if (bus.memReady_i) begin
                    bus.irWrite_o = 1'b1;
                    bus.pcWrite_o = 1'b1;
                    stateD        = StDecode;
                end
            end
            StDecode: stateD = isSupported(bus.ctrl_i) ? StExec : StTrap;
            StExec: begin
                case (opQ)
                    OpRType: begin
                        stateD = StWb;
                        if (functQ == FnSll) begin
                            bus.aluOp_o   = AluSll;
                            bus.aluSrcA_o = 1'b1;
                        end else if (functQ == FnSrl) begin
                            bus.aluOp_o   = rotQ ? AluRotr : AluSrl;
                            bus.aluSrcA_o = 1'b1;
                        end else begin
                            bus.aluOp_o = AluRType;
                        end
                    end
                    OpAddi: begin bus.aluOp_o = AluAddi; bus.aluSrcB_o = 1'b1; stateD = StWb; end
                    OpAndi: begin bus.aluOp_o = AluAndi; bus.aluSrcB_o = 1'b1; stateD = StWb; end
                    OpOri:  begin bus.aluOp_o = AluOri;  bus.aluSrcB_o = 1'b1; stateD = StWb; end
                    OpSlti: begin bus.aluOp_o = AluSlti; bus.aluSrcB_o = 1'b1; stateD = StWb; end
                    OpXori: begin bus.aluOp_o = AluXori; bus.aluSrcB_o = 1'b1; stateD = StWb; end
                    OpLw, OpSw: begin
                        bus.aluOp_o   = AluAddr;
                        bus.aluSrcB_o = 1'b1;
                        stateD        = StMem;
                    end
                    OpBeq:  begin bus.aluOp_o = AluBranch; bus.branchType_o = 2'b01; stateD = StFetch; end
                    OpBne:  begin bus.aluOp_o = AluBranch; bus.branchType_o = 2'b10; stateD = StFetch; end
                    OpBgtz: begin bus.aluOp_o = AluBranch; bus.branchType_o = 2'b11; stateD = StFetch; end
                    OpJ: begin
                        bus.jump_o = 1'b1;
                        stateD     = StFetch;
                    end
                    default: stateD = StTrap;
                endcase
            end
            StMem: begin
                // Request held constant while memory stalls.
                bus.iOrD_o       = 1'b1;
                bus.memToRead_o  = (opQ == OpLw);
                bus.memToWrite_o = (opQ != OpLw);
                if (bus.memReady_i) begin
                    stateD = (opQ == OpLw) ? StWb : StFetch;
                end
            end
            StWb: begin
                bus.regWrite_o = 1'b1;
                bus.regDst_o   = (opQ == OpRType);
                bus.memToReg_o = (opQ == OpLw);
                stateD         = StFetch;
            end
            StTrap:  stateD = StTrap;
            default: stateD = StFetch;
        endcase

        // No strobe may leak out while reset is held.
        if (rst_i) begin
            bus.pcWrite_o    = 1'b0;
            bus.irWrite_o    = 1'b0;
            bus.iOrD_o       = 1'b0;
            bus.memToRead_o  = 1'b0;
            bus.memToWrite_o = 1'b0;
            bus.regDst_o     = 1'b0;
            bus.memToReg_o   = 1'b0;
            bus.regWrite_o   = 1'b0;
            bus.aluSrcA_o    = 1'b0;
            bus.aluSrcB_o    = 1'b0;
            bus.aluOp_o      = '0;
            bus.branchType_o = 2'b00;
            bus.jump_o       = 1'b0;
        end
    end

    assign bus.state_o   = stateQ;
    assign bus.illegal_o = illegalQ;

`ifdef MC_RETIRE_COUNT_EN
    logic        retire;
    logic [31:0] retiredQ;

    always_comb begin
        retire = 1'b0;
        case (stateQ)
            StWb:    retire = 1'b1;
            StMem:   retire = (opQ == OpSw) && bus.memReady_i;
            StExec:  retire = (opQ == OpBeq) || (opQ == OpBne) || (opQ == OpBgtz) || (opQ == OpJ);
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retiredQ <= '0;
        end else if (retire) begin
            retiredQ <= retiredQ + 32'd1;
        end
    end

    assign bus.retired_o = retiredQ;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a phase-sequence model.
// Honours MC_RETIRE_COUNT_EN when the design is built with it.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic       pcWrite;
        logic       irWrite;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic       aluSrcB;
        logic [3:0] aluOp;
        logic [1:0] branchType;
        logic       jump;
        logic       illegal;
    } ctrlT;

    localparam logic [5:0] OpR = 6'b000000, OpAddi = 6'b001000, OpAndi = 6'b001100;
    localparam logic [5:0] OpOri = 6'b001101, OpSlti = 6'b001010, OpXori = 6'b001110;
    localparam logic [5:0] OpLw = 6'b100011, OpSw = 6'b101011, OpBeq = 6'b000100;
    localparam logic [5:0] OpBne = 6'b000101, OpBgtz = 6'b000111, OpJ = 6'b000010;

    int nChecks = 0;
    int nPass   = 0;

    // Observation log of one driven instruction.
    int         expPh[$];
    logic       rdyQ[$];
    logic [2:0] obsSt[$];
    ctrlT       obsCt[$];
    logic [2:0] endState;
    int unsigned retiredExp;
`ifdef MC_RETIRE_COUNT_EN
    logic [31:0] obsRetired;
`endif

    function automatic logic isIAlu(input logic [5:0] op);
        return op == OpAddi || op == OpAndi || op == OpOri || op == OpSlti || op == OpXori;
    endfunction

    // Expected control word for one phase of an instruction, straight from the op tables.
    function automatic ctrlT expectCtrl(input int ph, input logic [5:0] op, input logic [5:0] fn,
                                        input logic rot, input logic rdy);
        ctrlT c = '0;
        case (ph)
            0: begin c.memRead = 1'b1; c.irWrite = rdy; c.pcWrite = rdy; end
            2: begin
                if (op == OpR) begin
                    if (fn == 6'd0) begin c.aluOp = 4'b1000; c.aluSrcA = 1'b1; end
                    else if (fn == 6'd2) begin c.aluOp = rot ? 4'b1011 : 4'b1001; c.aluSrcA = 1'b1; end
                    else c.aluOp = 4'b0010;
                end
                else if (op == OpAddi) begin c.aluOp = 4'b0011; c.aluSrcB = 1'b1; end
                else if (op == OpAndi) begin c.aluOp = 4'b0100; c.aluSrcB = 1'b1; end
                else if (op == OpOri)  begin c.aluOp = 4'b0101; c.aluSrcB = 1'b1; end
                else if (op == OpSlti) begin c.aluOp = 4'b0110; c.aluSrcB = 1'b1; end
                else if (op == OpXori) begin c.aluOp = 4'b0111; c.aluSrcB = 1'b1; end
                else if (op == OpLw || op == OpSw) c.aluSrcB = 1'b1;
                else if (op == OpBeq)  begin c.aluOp = 4'b0001; c.branchType = 2'b01; end
                else if (op == OpBne)  begin c.aluOp = 4'b0001; c.branchType = 2'b10; end
                else if (op == OpBgtz) begin c.aluOp = 4'b0001; c.branchType = 2'b11; end
                else if (op == OpJ)    c.jump = 1'b1;
            end
            3: begin c.iOrD = 1'b1; c.memRead = (op == OpLw); c.memWrite = (op == OpSw); end
            4: begin c.regWrite = 1'b1; c.regDst = (op == OpR); c.memToReg = (op == OpLw); end
            7: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctrlT sampleCtrl();
        ctrlT c;
        c.pcWrite = bus.pcWrite_o;     c.irWrite = bus.irWrite_o;   c.iOrD = bus.iOrD_o;
        c.memRead = bus.memToRead_o;   c.memWrite = bus.memToWrite_o;
        c.regDst = bus.regDst_o;       c.memToReg = bus.memToReg_o; c.regWrite = bus.regWrite_o;
        c.aluSrcA = bus.aluSrcA_o;     c.aluSrcB = bus.aluSrcB_o;   c.aluOp = bus.aluOp_o;
        c.branchType = bus.branchType_o; c.jump = bus.jump_o;       c.illegal = bus.illegal_o;
        return c;
    endfunction

    // Runs one supported instruction with fw FETCH and mw MEM wait cycles; logs what it saw.
    // Entered and left at posedge+2 with the DUT expected in FETCH.
    task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn, input logic rot,
                               input int fw, input int mw);
        int f = 0;
        int m = 0;
        logic rdy;
        expPh.delete(); rdyQ.delete(); obsSt.delete(); obsCt.delete();
        repeat (fw + 1) expPh.push_back(0);
        expPh.push_back(1);
        expPh.push_back(2);
        if (op == OpLw || op == OpSw) repeat (mw + 1) expPh.push_back(3);
        if (op == OpR || op == OpLw || isIAlu(op)) expPh.push_back(4);
        foreach (expPh[i]) begin
            bus.ctrl_i     = 6'($urandom);
            bus.funct_i    = 6'($urandom);
            bus.rotation_i = 1'($urandom);
            if (expPh[i] == 1) begin
                bus.ctrl_i = op; bus.funct_i = fn; bus.rotation_i = rot;
            end
            if (expPh[i] == 0) begin rdy = (f == fw); f++; end
            else if (expPh[i] == 3) begin rdy = (m == mw); m++; end
            else rdy = 1'($urandom);
            bus.memReady_i = rdy;
            rdyQ.push_back(rdy);
            #1;
            obsSt.push_back(bus.state_o);
            obsCt.push_back(sampleCtrl());
            @(posedge clk);
            #2;
        end
        retiredExp++;
        endState = bus.state_o;
`ifdef MC_RETIRE_COUNT_EN
        obsRetired = bus.retired_o;
`endif
    endtask

    task automatic test_reset();
        ctrlT c;
        rst = 1'b1; bus.memReady_i = 1'b1; bus.ctrl_i = '0; bus.funct_i = '0; bus.rotation_i = 1'b0;
        retiredExp = 0;
        repeat (3) @(posedge clk);
        #2;
        c = sampleCtrl();
        nChecks++;
        if (bus.state_o !== 3'd0) $display("FAIL reset_state: got %0d want 0", bus.state_o);
        else nPass++;
        nChecks++;
        if (c !== '0) $display("FAIL reset_strobes: got %h want 0", c);
        else nPass++;
        rst = 1'b0;
        bus.memReady_i = 1'b0;
        #1;
        c = sampleCtrl();
        nChecks++;
        if (c !== expectCtrl(0, 6'd0, 6'd0, 1'b0, 1'b0))
            $display("FAIL fetch_wait_ctrl: got %h want %h", c, expectCtrl(0, 6'd0, 6'd0, 1'b0, 1'b0));
        else nPass++;
`ifdef MC_RETIRE_COUNT_EN
        nChecks++;
        if (bus.retired_o !== 32'd0) $display("FAIL reset_retired: got %0d want 0", bus.retired_o);
        else nPass++;
`endif
        @(posedge clk);
        #2;
    endtask

    task automatic test_addi();
        logic [5:0] fn = 6'($urandom);
        drive_instr(OpAddi, fn, 1'b0, 0, 0);
        foreach (expPh[i]) begin
            nChecks++;
            if (obsSt[i] !== 3'(expPh[i])) $display("FAIL addi_state[%0d]: got %0d want %0d", i, obsSt[i], expPh[i]);
            else nPass++;
            nChecks++;
            if (obsCt[i] !== expectCtrl(expPh[i], OpAddi, fn, 1'b0, rdyQ[i]))
                $display("FAIL addi_ctrl[%0d]: got %h want %h", i, obsCt[i], expectCtrl(expPh[i], OpAddi, fn, 1'b0, rdyQ[i]));
            else nPass++;
        end
        nChecks++;
        if (endState !== 3'd0) $display("FAIL addi_end: got %0d want 0", endState);
        else nPass++;
    endtask

    task automatic test_lw_wait();
        drive_instr(OpLw, 6'd5, 1'b0, 0, 2);
        foreach (expPh[i]) begin
            nChecks++;
            if (obsSt[i] !== 3'(expPh[i])) $display("FAIL lw_state[%0d]: got %0d want %0d", i, obsSt[i], expPh[i]);
            else nPass++;
            nChecks++;
            if (obsCt[i] !== expectCtrl(expPh[i], OpLw, 6'd5, 1'b0, rdyQ[i]))
                $display("FAIL lw_ctrl[%0d]: got %h want %h", i, obsCt[i], expectCtrl(expPh[i], OpLw, 6'd5, 1'b0, rdyQ[i]));
            else nPass++;
        end
        nChecks++;
        if (endState !== 3'd0) $display("FAIL lw_end: got %0d want 0", endState);
        else nPass++;
    endtask

    task automatic test_rotr_srl();
        for (int r = 1; r >= 0; r--) begin
            drive_instr(OpR, 6'b000010, 1'(r), 0, 0);
            foreach (expPh[i]) begin
                nChecks++;
                if (obsSt[i] !== 3'(expPh[i])) $display("FAIL shift%0d_state[%0d]: got %0d want %0d", r, i, obsSt[i], expPh[i]);
                else nPass++;
                nChecks++;
                if (obsCt[i] !== expectCtrl(expPh[i], OpR, 6'b000010, 1'(r), rdyQ[i]))
                    $display("FAIL shift%0d_ctrl[%0d]: got %h want %h", r, i, obsCt[i],
                             expectCtrl(expPh[i], OpR, 6'b000010, 1'(r), rdyQ[i]));
                else nPass++;
            end
        end
    endtask

    task automatic test_bne_j();
        logic [5:0] ops [2];
        ops[0] = OpBne; ops[1] = OpJ;
        for (int k = 0; k < 2; k++) begin
            drive_instr(ops[k], 6'd9, 1'b1, 0, 0);
            foreach (expPh[i]) begin
                nChecks++;
                if (obsSt[i] !== 3'(expPh[i])) $display("FAIL br%0d_state[%0d]: got %0d want %0d", k, i, obsSt[i], expPh[i]);
                else nPass++;
                nChecks++;
                if (obsCt[i] !== expectCtrl(expPh[i], ops[k], 6'd9, 1'b1, rdyQ[i]))
                    $display("FAIL br%0d_ctrl[%0d]: got %h want %h", k, i, obsCt[i],
                             expectCtrl(expPh[i], ops[k], 6'd9, 1'b1, rdyQ[i]));
                else nPass++;
            end
            nChecks++;
            if (endState !== 3'd0) $display("FAIL br%0d_end: got %0d want 0", k, endState);
            else nPass++;
        end
    endtask

    task automatic test_random();
        logic [5:0] legalOps [12];
        logic [5:0] op, fn;
        logic       rot;
        legalOps = '{OpR, OpAddi, OpAndi, OpOri, OpSlti, OpXori, OpLw, OpSw, OpBeq, OpBne, OpBgtz, OpJ};
        for (int n = 0; n < 60; n++) begin
            op  = legalOps[$urandom_range(11, 0)];
            case ($urandom_range(2, 0))
                0:       fn = 6'd0;
                1:       fn = 6'd2;
                default: fn = 6'($urandom);
            endcase
            rot = 1'($urandom);
            drive_instr(op, fn, rot, $urandom_range(2, 0), $urandom_range(3, 0));
            foreach (expPh[i]) begin
                nChecks++;
                if (obsSt[i] !== 3'(expPh[i])) $display("FAIL rnd%0d_state[%0d]: got %0d want %0d", n, i, obsSt[i], expPh[i]);
                else nPass++;
                nChecks++;
                if (obsCt[i] !== expectCtrl(expPh[i], op, fn, rot, rdyQ[i]))
                    $display("FAIL rnd%0d_ctrl[%0d] op %b: got %h want %h", n, i, op, obsCt[i],
                             expectCtrl(expPh[i], op, fn, rot, rdyQ[i]));
                else nPass++;
            end
            nChecks++;
            if (endState !== 3'd0) $display("FAIL rnd%0d_end: got %0d want 0", n, endState);
            else nPass++;
`ifdef MC_RETIRE_COUNT_EN
            nChecks++;
            if (obsRetired !== retiredExp) $display("FAIL rnd%0d_retired: got %0d want %0d", n, obsRetired, retiredExp);
            else nPass++;
`endif
        end
    endtask

    task automatic test_reset_mid_mem();
        bus.memReady_i = 1'b1; bus.ctrl_i = 6'($urandom);
        @(posedge clk); #2;
        bus.ctrl_i = OpSw; bus.memReady_i = 1'b0;
        @(posedge clk); #2;
        bus.ctrl_i = 6'($urandom);
        @(posedge clk); #2;
        bus.memReady_i = 1'b0;
        #1;
        nChecks++;
        if (bus.state_o !== 3'd3 || bus.memToWrite_o !== 1'b1)
            $display("FAIL sw_in_mem: got state %0d wr %b want 3/1", bus.state_o, bus.memToWrite_o);
        else nPass++;
        #1;
        rst = 1'b1;
        retiredExp = 0;
        #1;
        nChecks++;
        if (bus.memToWrite_o !== 1'b0) $display("FAIL rst_mem_wr: got %b want 0", bus.memToWrite_o);
        else nPass++;
        nChecks++;
        if (sampleCtrl() !== '0) $display("FAIL rst_mem_strobes: got %h want 0", sampleCtrl());
        else nPass++;
        @(posedge clk); #2;
        nChecks++;
        if (bus.state_o !== 3'd0 || bus.illegal_o !== 1'b0)
            $display("FAIL rst_mem_state: got %0d ill %b want 0/0", bus.state_o, bus.illegal_o);
        else nPass++;
        rst = 1'b0;
    endtask

    task automatic test_trap();
        bus.memReady_i = 1'b1; bus.ctrl_i = 6'($urandom);
        @(posedge clk); #2;
        bus.ctrl_i = 6'b111111;
        #1;
        nChecks++;
        if (bus.state_o !== 3'd1) $display("FAIL trap_decode: got %0d want 1", bus.state_o);
        else nPass++;
        @(posedge clk); #2;
        for (int i = 0; i < 10; i++) begin
            bus.ctrl_i = 6'($urandom); bus.memReady_i = 1'($urandom);
            #1;
            nChecks++;
            if (bus.state_o !== 3'd7) $display("FAIL trap_state[%0d]: got %0d want 7", i, bus.state_o);
            else nPass++;
            nChecks++;
            if (sampleCtrl() !== expectCtrl(7, 6'd0, 6'd0, 1'b0, 1'b0))
                $display("FAIL trap_ctrl[%0d]: got %h want %h", i, sampleCtrl(), expectCtrl(7, 6'd0, 6'd0, 1'b0, 1'b0));
            else nPass++;
`ifdef MC_RETIRE_COUNT_EN
            nChecks++;
            if (bus.retired_o !== retiredExp) $display("FAIL trap_retired[%0d]: got %0d want %0d", i, bus.retired_o, retiredExp);
            else nPass++;
`endif
            @(posedge clk); #2;
        end
        rst = 1'b1;
        #1;
        nChecks++;
        if (bus.illegal_o !== 1'b0 || bus.state_o !== 3'd0)
            $display("FAIL trap_reset: got ill %b state %0d want 0/0", bus.illegal_o, bus.state_o);
        else nPass++;
        @(posedge clk); #2;
        rst = 1'b0;
        retiredExp = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw_wait();
        test_rotr_srl();
        test_bne_j();
        test_random();
        test_reset_mid_mem();
        test_addi();
        test_trap();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
